micro_sequencer: RTL and testbench
==================================

// Module: micro_sequencer
// PURPOSE
//  Parametrised microprogrammed control sequencer for the CPU datapath; next generation of controlUnit.
//  Holds a loadable microstore and steps a microaddress register, emitting one control word per cycle.
//  Adds over controlUnit: parametrised control-word width and microstore depth, condition branching,
//  call/return stack, MOC wait with timeout, and an error trap.
//  Sits between the IR decoder (supplies decode_addr) and all datapath/RAM control inputs.
// PARAMETERS
//  ADDR_W      8    microaddress width; microstore depth = 2**ADDR_W
//  CW_W        48   control word width (RFLd, IRLd, MARLd, mux selects, OP, ...)
//  NCOND       4    condition inputs (>=2); CS_W = $clog2(NCOND)
//  STACK_DEPTH 2    call/return stack entries (>=1)
//  TIMEOUT     16   max cycles in WAIT_MOC before trap (>=1)
//  RESET_ADDR  0    microaddress loaded on reset and HALT
//  ERR_ADDR    255  microaddress jumped to on trap
// PORTS
//  CLK          in   1        clock, rising edge
//  CLR          in   1        reset, asynchronous, active-high
//  ld_en        in   1        microstore write strobe (LOAD state only)
//  ld_addr      in   ADDR_W   microstore write address
//  ld_data      in   MI_W     microinstruction; MI_W = CW_W+3+CS_W+1+ADDR_W
//  start        in   1        pulse: LOAD -> RUN
//  moc          in   1        memory operation complete
//  cond         in   NCOND    datapath condition flags
//  decode_addr  in   ADDR_W   entry point from IR decoder
//  cw           out  CW_W     control word; 0 when not RUN/STALL
//  uaddr        out  ADDR_W   current microaddress
//  running      out  1        state is RUN or STALL
//  stalled      out  1        state is STALL
//  err          out  1        sticky trap flag
// BEHAVIOUR
//  MI layout MSB->LSB: {ctrl[CW_W], nsf[3], csel[CS_W], cinv, target[ADDR_W]}; mi = store[uaddr], async read.
//  States: LOAD, RUN, STALL. Reset (any time, incl. mid-run): state=LOAD, uaddr=RESET_ADDR, stack empty,
//   timeout cnt=0, err=0, cw=0, running=0, stalled=0. Microstore contents NOT cleared by CLR.
//  LOAD: ld_en writes store[ld_addr]<=ld_data at clock edge; start -> RUN next cycle (uaddr unchanged).
//   ld_en+start same cycle: write lands; first RUN cycle reads updated word. start in RUN/STALL ignored;
//   ld_en outside LOAD ignored.
//  RUN/STALL: cw = mi.ctrl combinationally. Per rising edge, by nsf:
//   0 INC:  uaddr<=uaddr+1 (wraps mod 2**ADDR_W)
//   1 JUMP: uaddr<=target
//   2 DECODE: uaddr<=decode_addr (sampled that edge)
//   3 COND: (cond[csel]^cinv) ? target : uaddr+1; csel>=NCOND evaluates as 0
//   4 WAIT_MOC: moc=1 -> uaddr+1, state RUN, cnt=0; moc=0 -> hold uaddr, state STALL, cnt+1;
//      moc=0 with cnt==TIMEOUT-1 -> trap. moc sampled same cycle as entry: zero-stall advance.
//   5 CALL: stack not full -> push uaddr+1, uaddr<=target; full -> trap
//   6 RET:  stack not empty -> uaddr<=pop; empty -> trap
//   7 HALT: state<=LOAD, uaddr<=RESET_ADDR; stack kept
//  Trap: uaddr<=ERR_ADDR, err<=1, state RUN, cnt=0, stack cleared; err clears only on CLR.
//  cw held stable across all STALL cycles (same uaddr).
// TESTING
//  1 load {INC,INC,JUMP->0} at 0..2, start -> uaddr 0,1,2,0,1; cw = ctrl of each word; CLR mid-run -> cw=0, uaddr=0, running=0.
//  2 WAIT_MOC, moc low 3 cycles then high -> uaddr held 4 cycles, stalled=1 x3, cw constant, then uaddr+1.
//  3 TIMEOUT=8, WAIT_MOC, moc never high -> after 8 cycles uaddr=ERR_ADDR, err=1 until CLR.
//  4 COND csel=2, target=0x20: cond=4'b0100,cinv=0 -> 0x20; cinv=1 -> uaddr+1; uaddr=255 INC -> 0.
//  5 CALL@0->0x10, CALL@0x10->0x30, RET, RET -> 0x10,0x30,0x11,0x01; third nested CALL -> trap.
//  6 DECODE with decode_addr=0x40 -> uaddr=0x40; HALT -> LOAD, cw=0, uaddr=0; RET on empty -> err=1.

Source files
------------

// File: rtl/micro_sequencer.sv
// ---------------------------------------------------------------------------
// micro_sequencer
//
// Microprogrammed control sequencer for the CPU datapath. A loadable microstore
// is addressed by a microaddress register. Each cycle the addressed
// microinstruction supplies one control word, and its next-step field chooses
// the following microaddress. The choices are increment, jump, decode entry,
// conditional branch, wait for memory with a timeout, call, return and halt.
// Stack overflow, stack underflow and memory timeout all trap to ERR_ADDR and
// set a sticky error flag.
//
// Microinstruction layout, MSB to LSB:
//   {ctrl[CW_W], nsf[3], csel[CS_W], cinv, target[ADDR_W]}
//
// Ports
//   CLK          in   1        clock, rising edge
//   CLR          in   1        asynchronous active-high reset
//   ld_en        in   1        microstore write strobe, honoured in LOAD only
//   ld_addr      in   ADDR_W   microstore write address
//   ld_data      in   MI_W     microinstruction to write
//   start        in   1        pulse that moves LOAD to RUN
//   moc          in   1        memory operation complete
//   cond         in   NCOND    datapath condition flags
//   decode_addr  in   ADDR_W   entry point from the IR decoder
//   cw           out  CW_W     control word; zero outside RUN/STALL
//   uaddr        out  ADDR_W   current microaddress
//   running      out  1        state is RUN or STALL
//   stalled      out  1        state is STALL
//   err          out  1        sticky trap flag, cleared only by CLR
// ---------------------------------------------------------------------------
module micro_sequencer #(
    parameter int ADDR_W      = 8,
    parameter int CW_W        = 48,
    parameter int NCOND       = 4,
    parameter int STACK_DEPTH = 2,
    parameter int TIMEOUT     = 16,
    parameter int RESET_ADDR  = 0,
    parameter int ERR_ADDR    = 255,
    localparam int CS_W       = $clog2(NCOND),
    localparam int MI_W       = CW_W + 3 + CS_W + 1 + ADDR_W
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [MI_W-1:0]   ld_data,
    input  logic              start,
    input  logic              moc,
    input  logic [NCOND-1:0]  cond,
    input  logic [ADDR_W-1:0] decode_addr,
    output logic [CW_W-1:0]   cw,
    output logic [ADDR_W-1:0] uaddr,
    output logic              running,
    output logic              stalled,
    output logic              err
);

    // Sizes of internal counters
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int CX_W  = 2 ** CS_W;

    // Sequencer states
    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;

    // Next-step field encodings
    localparam logic [2:0] NSF_INC    = 3'd0;
    localparam logic [2:0] NSF_JUMP   = 3'd1;
    localparam logic [2:0] NSF_DECODE = 3'd2;
    localparam logic [2:0] NSF_COND   = 3'd3;
    localparam logic [2:0] NSF_WAIT   = 3'd4;
    localparam logic [2:0] NSF_CALL   = 3'd5;
    localparam logic [2:0] NSF_RET    = 3'd6;
    localparam logic [2:0] NSF_HALT   = 3'd7;

    typedef struct packed {
        logic [CW_W-1:0]   ctrl;
        logic [2:0]        nsf;
        logic [CS_W-1:0]   csel;
        logic              cinv;
        logic [ADDR_W-1:0] target;
    } mi_t;

    // Storage and registered state
    logic [MI_W-1:0]   store [DEPTH];
    logic [ADDR_W-1:0] stack [STACK_DEPTH];
    logic [1:0]        state;
    logic [SP_W-1:0]   sp;
    logic [CNT_W-1:0]  cnt;

    // Combinational next-state values
    mi_t               mi;
    logic [ADDR_W-1:0] uaddr_inc;
    logic [CX_W-1:0]   cond_ext;
    logic              cond_hit;
    logic [ADDR_W-1:0] pop_val;
    logic              stack_full;
    logic              stack_empty;
    logic [1:0]        nxt_state;
    logic [ADDR_W-1:0] nxt_uaddr;
    logic [SP_W-1:0]   nxt_sp;
    logic [CNT_W-1:0]  nxt_cnt;
    logic              nxt_err;
    logic              push_en;
    logic              trap;

    // Asynchronous microstore read
    assign mi        = mi_t'(store[uaddr]);
    assign uaddr_inc = uaddr + ADDR_W'(1);

    assign running = (state == ST_RUN) || (state == ST_STALL);
    assign stalled = (state == ST_STALL);
    assign cw      = running ? mi.ctrl : '0;

    assign stack_full  = (sp == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp == '0);

    // The condition vector is padded to a power of two. A csel that names a
    // flag which does not exist then reads as 0 without an out-of-range index.
    always_comb begin
        // NOTE: assign every always_comb output a default first so no path can infer a latch.
        cond_ext             = '0;
        cond_ext[NCOND-1:0]  = cond;
    end
    assign cond_hit = cond_ext[mi.csel] ^ mi.cinv;

    // Top of stack is the entry just below the stack pointer.
    always_comb begin
        pop_val = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (SP_W'(i + 1) == sp) pop_val = stack[i];
        end
    end

    // Next-state logic
    always_comb begin
        nxt_state = state;
        nxt_uaddr = uaddr;
        nxt_sp    = sp;
        nxt_cnt   = cnt;
        nxt_err   = err;
        push_en   = 1'b0;
        trap      = 1'b0;

        case (state)
            ST_LOAD: begin
                if (start) nxt_state = ST_RUN;
            end
            ST_RUN, ST_STALL: begin
                // The wait counter only counts inside WAIT_MOC. Every other
                // step leaves it at zero.
                nxt_state = ST_RUN;
                nxt_cnt   = '0;
                case (mi.nsf)
                    NSF_INC:    nxt_uaddr = uaddr_inc;
                    NSF_JUMP:   nxt_uaddr = mi.target;
                    NSF_DECODE: nxt_uaddr = decode_addr;
                    NSF_COND:   nxt_uaddr = cond_hit ? mi.target : uaddr_inc;
                    NSF_WAIT: begin
                        if (moc) begin
                            nxt_uaddr = uaddr_inc;
                        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                            trap = 1'b1;
                        end else begin
                            nxt_state = ST_STALL;
                            nxt_cnt   = cnt + CNT_W'(1);
                        end
                    end
                    NSF_CALL: begin
                        if (stack_full) begin
                            trap = 1'b1;
                        end else begin
                            push_en   = 1'b1;
                            nxt_sp    = sp + SP_W'(1);
                            nxt_uaddr = mi.target;
                        end
                    end
                    NSF_RET: begin
                        if (stack_empty) begin
                            trap = 1'b1;
                        end else begin
                            nxt_sp    = sp - SP_W'(1);
                            nxt_uaddr = pop_val;
                        end
                    end
                    default: begin
                        // HALT returns to LOAD. The stack is left as it is.
                        nxt_state = ST_LOAD;
                        nxt_uaddr = ADDR_W'(RESET_ADDR);
                    end
                endcase
            end
            default: begin
                // Unreachable encoding: recover to LOAD.
                nxt_state = ST_LOAD;
                nxt_uaddr = ADDR_W'(RESET_ADDR);
            end
        endcase

        // A trap overrides whatever the step computed.
        if (trap) begin
            nxt_state = ST_RUN;
            nxt_uaddr = ADDR_W'(ERR_ADDR);
            nxt_err   = 1'b1;
            nxt_cnt   = '0;
            nxt_sp    = '0;
            push_en   = 1'b0;
        end
    end

    // Control registers
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state <= ST_LOAD;
            uaddr <= ADDR_W'(RESET_ADDR);
            sp    <= '0;
            cnt   <= '0;
            err   <= 1'b0;
        end else begin
            state <= nxt_state;
            uaddr <= nxt_uaddr;
            sp    <= nxt_sp;
            cnt   <= nxt_cnt;
            err   <= nxt_err;
        end
    end

    // Microstore write port
    // NOTE: memories get no reset. The microstore keeps its program across CLR, and the stack is emptied through sp alone.
    always_ff @(posedge CLK) begin
        if (state == ST_LOAD && ld_en) store[ld_addr] <= ld_data;
    end

    // Return-address stack write port
    always_ff @(posedge CLK) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (push_en && SP_W'(i) == sp) stack[i] <= uaddr_inc;
        end
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// ---------------------------------------------------------------------------
// tb_micro_sequencer
//
// Directed testbench for micro_sequencer, built with TIMEOUT=8. It loads short
// microprograms, runs them and compares outputs against hand-computed values.
// Inputs change 1 ns after a rising edge, and outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_micro_sequencer;

    localparam int ADDR_W = 8;
    localparam int CW_W   = 48;
    localparam int NCOND  = 4;
    localparam int MI_W   = CW_W + 3 + 2 + 1 + ADDR_W;

    localparam logic [2:0] INC = 3'd0, JUMP = 3'd1, DECODE = 3'd2, COND = 3'd3,
                           WAITM = 3'd4, CALL = 3'd5, RET = 3'd6, HALT = 3'd7;

    logic              CLK = 1'b0;
    logic              CLR;
    logic              ld_en;
    logic [ADDR_W-1:0] ld_addr;
    logic [MI_W-1:0]   ld_data;
    logic              start;
    logic              moc;
    logic [NCOND-1:0]  cond;
    logic [ADDR_W-1:0] decode_addr;
    logic [CW_W-1:0]   cw;
    logic [ADDR_W-1:0] uaddr;
    logic              running;
    logic              stalled;
    logic              err;

    int total = 0;
    int bad   = 0;

    micro_sequencer #(
        .ADDR_W(ADDR_W), .CW_W(CW_W), .NCOND(NCOND), .STACK_DEPTH(2),
        .TIMEOUT(8), .RESET_ADDR(0), .ERR_ADDR(255)
    ) dut (
        .CLK(CLK), .CLR(CLR), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .start(start), .moc(moc), .cond(cond), .decode_addr(decode_addr),
        .cw(cw), .uaddr(uaddr), .running(running), .stalled(stalled), .err(err)
    );

    always #5 CLK = ~CLK;

    // Control word pattern tied to the word's address, so cw shows which word is live
    function automatic logic [CW_W-1:0] cwof(input logic [7:0] a);
        return {40'hC0DE_5EED_00, a};
    endfunction

    function automatic logic [MI_W-1:0] mk(input logic [7:0] a, input logic [2:0] nsf,
                                           input logic [1:0] csel, input logic cinv,
                                           input logic [7:0] target);
        return {cwof(a), nsf, csel, cinv, target};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic load(input logic [7:0] a, input logic [MI_W-1:0] d, input logic s);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        start   = s;
        step();
        ld_en   = 1'b0;
        start   = 1'b0;
    endtask

    task automatic expect_at(input string tag, input logic [7:0] a);
        check({tag, "_uaddr"}, 64'(uaddr), 64'(a));
        check({tag, "_cw"}, 64'(cw), 64'(cwof(a)));
    endtask

    task automatic do_reset();
        CLR = 1'b1;
        #2;
        CLR = 1'b0;
    endtask

    initial begin
        CLR = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0; start = 1'b0;
        moc = 1'b0; cond = '0; decode_addr = '0;
        repeat (2) step();
        check("rst_running", 64'(running), 64'(0));
        check("rst_stalled", 64'(stalled), 64'(0));
        check("rst_uaddr", 64'(uaddr), 64'(0));
        check("rst_cw", 64'(cw), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        CLR = 1'b0;

        // 1: INC, INC, JUMP 0. Address 0 is written in the same cycle as start.
        load(8'h01, mk(8'h01, INC, 0, 0, 0), 0);
        load(8'h02, mk(8'h02, JUMP, 0, 0, 8'h00), 0);
        load(8'h0FF, mk(8'hFF, INC, 0, 0, 0), 0);
        check("load_cw_zero", 64'(cw), 64'(0));
        load(8'h00, mk(8'h00, INC, 0, 0, 0), 1);
        check("t1_running", 64'(running), 64'(1));
        expect_at("t1_a0", 8'h00);
        // A write while running must be ignored.
        ld_en = 1'b1; ld_addr = 8'h01; ld_data = mk(8'h77, HALT, 0, 0, 0);
        step();
        ld_en = 1'b0;
        expect_at("t1_a1", 8'h01);
        step(); expect_at("t1_a2", 8'h02);
        step(); expect_at("t1_a0b", 8'h00);
        step(); expect_at("t1_a1b", 8'h01);
        // Asynchronous CLR in mid-run
        #2 CLR = 1'b1;
        #1;
        check("t1_clr_cw", 64'(cw), 64'(0));
        check("t1_clr_uaddr", 64'(uaddr), 64'(0));
        check("t1_clr_running", 64'(running), 64'(0));
        CLR = 1'b0;
        step();

        // 2: WAIT_MOC held for 3 cycles, then moc arrives
        load(8'h50, mk(8'h50, WAITM, 0, 0, 0), 0);
        load(8'h51, mk(8'h51, HALT, 0, 0, 0), 0);
        load(8'h00, mk(8'h00, JUMP, 0, 0, 8'h50), 1);
        expect_at("t2_a0", 8'h00);
        step();
        expect_at("t2_enter", 8'h50);
        check("t2_enter_stalled", 64'(stalled), 64'(0));
        for (int i = 1; i <= 3; i++) begin
            step();
            expect_at("t2_hold", 8'h50);
            check("t2_stalled", 64'(stalled), 64'(1));
        end
        moc = 1'b1;
        step();
        moc = 1'b0;
        expect_at("t2_adv", 8'h51);
        check("t2_adv_stalled", 64'(stalled), 64'(0));
        step();
        // The HALT at 0x51 returns to LOAD.
        check("t2_halt_running", 64'(running), 64'(0));
        check("t2_halt_uaddr", 64'(uaddr), 64'(0));
        check("t2_halt_cw", 64'(cw), 64'(0));

        // 3: no moc, so the timeout traps after 8 cycles in WAIT_MOC
        start = 1'b1; step(); start = 1'b0;
        expect_at("t3_a0", 8'h00);
        step();
        expect_at("t3_enter", 8'h50);
        repeat (7) step();
        check("t3_last_hold", 64'(uaddr), 64'(8'h50));
        check("t3_last_err", 64'(err), 64'(0));
        step();
        expect_at("t3_trap", 8'hFF);
        check("t3_err", 64'(err), 64'(1));
        check("t3_trap_stalled", 64'(stalled), 64'(0));
        step();
        // INC at 0xFF wraps to 0. err stays set.
        expect_at("t4_wrap", 8'h00);
        check("t3_err_sticky", 64'(err), 64'(1));
        do_reset();
        check("t3_err_clr", 64'(err), 64'(0));
        step();

        // 4: COND with csel=2 and cond=0100
        cond = 4'b0100;
        load(8'h20, mk(8'h20, HALT, 0, 0, 0), 0);
        load(8'h01, mk(8'h01, HALT, 0, 0, 0), 0);
        load(8'h00, mk(8'h00, COND, 2, 0, 8'h20), 1);
        step(); expect_at("t4_taken", 8'h20);
        step(); check("t4_halt1", 64'(running), 64'(0));
        load(8'h00, mk(8'h00, COND, 2, 1, 8'h20), 1);
        step(); expect_at("t4_inv_fall", 8'h01);
        step(); check("t4_halt2", 64'(running), 64'(0));
        cond = '0;

        // 5: nested CALL and RET, then a third nested CALL overflows
        load(8'h10, mk(8'h10, CALL, 0, 0, 8'h30), 0);
        load(8'h30, mk(8'h30, RET, 0, 0, 0), 0);
        load(8'h11, mk(8'h11, RET, 0, 0, 0), 0);
        load(8'h01, mk(8'h01, CALL, 0, 0, 8'h71), 0);
        load(8'h71, mk(8'h71, CALL, 0, 0, 8'h72), 0);
        load(8'h72, mk(8'h72, CALL, 0, 0, 8'h73), 0);
        load(8'h00, mk(8'h00, CALL, 0, 0, 8'h10), 1);
        step(); expect_at("t5_call1", 8'h10);
        step(); expect_at("t5_call2", 8'h30);
        step(); expect_at("t5_ret1", 8'h11);
        step(); expect_at("t5_ret2", 8'h01);
        step(); expect_at("t5_n1", 8'h71);
        step(); expect_at("t5_n2", 8'h72);
        check("t5_err_pre", 64'(err), 64'(0));
        step(); expect_at("t5_overflow", 8'hFF);
        check("t5_err", 64'(err), 64'(1));
        do_reset();
        step();

        // 6: DECODE, a zero-stall WAIT_MOC, then RET on an empty stack
        decode_addr = 8'h40;
        load(8'h40, mk(8'h40, WAITM, 0, 0, 0), 0);
        load(8'h41, mk(8'h41, RET, 0, 0, 0), 0);
        load(8'h00, mk(8'h00, DECODE, 0, 0, 0), 1);
        moc = 1'b1;
        step(); expect_at("t6_decode", 8'h40);
        step(); expect_at("t6_nostall", 8'h41);
        check("t6_nostall_flag", 64'(stalled), 64'(0));
        moc = 1'b0;
        step(); expect_at("t6_underflow", 8'hFF);
        check("t6_err", 64'(err), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
